// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state encoding, register address width, NOP word.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on inc_i, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use stalls, taken-branch
// squash, data-memory wait freeze, plus saturating event counters.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  start_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic                  ex_memrd_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  mem_pcsrc_i,
  input  logic                  mem_access_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_we_o,
  output logic                  ifid_we_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  idex_flush_o,
  output logic                  exmem_flush_o,
  output logic                  hold_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      wait_cnt_o,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] LP_MAX     = {CNT_W{1'b1}};

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wrun, w_wrun_nxt;
  logic             r_err;
  logic             w_lu, w_mw, w_active;
  logic             w_stall_inc, w_flush_inc, w_wait_inc;

  // x0 as destination never creates a dependency.
  assign w_lu = ex_memrd_i && (ex_rd_i != '0) &&
                ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                 (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  assign w_mw     = mem_access_i && !dmem_ready_i;
  assign w_active = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);

  // State register.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: IDLE leaves on the first running edge; wait lasts while memory stalls.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:     w_state_nxt = ST_RUN;
      ST_RUN:      w_state_nxt = w_mw ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: w_state_nxt = w_mw ? ST_MEM_WAIT : ST_RUN;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: memory wait beats branch squash beats load-use stall.
  always_comb begin
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    hold_o        = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_wait_inc    = 1'b0;
    if (w_active) begin
      if (w_mw) begin
        hold_o     = 1'b1;
        w_wait_inc = 1'b1;
      end else if (mem_pcsrc_i) begin
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
        w_flush_inc   = 1'b1;
      end else if (w_lu) begin
        idex_bubble_o = 1'b1;
        w_stall_inc   = 1'b1;
      end else begin
        pc_we_o   = 1'b1;
        ifid_we_o = 1'b1;
      end
    end else begin
      // IDLE and the unreachable encoding keep the pipe flushed.
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end
  end

  // Wait-run length: restarts at 1 on the first wait cycle after RUN.
  always_comb begin
    if (r_state == ST_RUN)       w_wrun_nxt = CNT_W'(1);
    else if (r_wrun == LP_MAX)   w_wrun_nxt = r_wrun;
    else                         w_wrun_nxt = r_wrun + 1'b1;
  end

  // Track the current wait run and raise the sticky timeout flag.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_wrun <= '0;
      r_err  <= 1'b0;
    end else if (w_active && w_mw) begin
      r_wrun <= w_wrun_nxt;
      if (w_wrun_nxt >= LP_TIMEOUT) r_err <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i), .rst_ni(start_i), .inc_i(w_stall_inc), .cnt_o(stall_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i), .rst_ni(start_i), .inc_i(w_flush_inc), .cnt_o(flush_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk_i (clk_i), .rst_ni(start_i), .inc_i(w_wait_inc), .cnt_o(wait_cnt_o)
  );

  assign state_o = r_state;
  assign err_o   = r_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with CNT_W=4, MEM_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             start_i;
  logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
  logic             id_use_rs1_i, id_use_rs2_i, ex_memrd_i;
  logic             mem_pcsrc_i, mem_access_i, dmem_ready_i;
  logic             pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o;
  logic             idex_flush_o, exmem_flush_o, hold_o, err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_memrd_i(ex_memrd_i), .ex_rd_i(ex_rd_i),
    .mem_pcsrc_i(mem_pcsrc_i), .mem_access_i(mem_access_i),
    .dmem_ready_i(dmem_ready_i),
    .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .idex_flush_o(idex_flush_o),
    .exmem_flush_o(exmem_flush_o), .hold_o(hold_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .wait_cnt_o(wait_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; ex_memrd_i = 1'b0;
    mem_pcsrc_i = 1'b0; mem_access_i = 1'b0; dmem_ready_i = 1'b1;
  endtask

  // Load into x5 in EX while the ID instruction reads x5 through rs2.
  task automatic set_lu();
    ex_memrd_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_use_rs2_i = 1'b1;
    id_rs1_i = 5'd3; id_use_rs1_i = 1'b1;
  endtask

  initial begin
    start_i = 1'b0;
    clr_in();
    #3;
    check("rst_state", 32'(state_o), 0);
    check("rst_pc_we", 32'(pc_we_o), 0);
    check("rst_flushes", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 32'h7);
    check("rst_hold", 32'(hold_o), 0);
    check("rst_cnts", {20'd0, stall_cnt_o, flush_cnt_o, wait_cnt_o}, 0);
    check("rst_err", 32'(err_o), 0);
    tick();
    start_i = 1'b1;
    #1;
    check("idle_before_edge", 32'(state_o), 0);
    tick();
    check("run_state", 32'(state_o), 1);
    check("run_pc_we", 32'(pc_we_o), 1);
    check("run_flush_off", 32'(ifid_flush_o), 0);

    // Load-use on rs2.
    set_lu();
    #1;
    check("lu_pc_we", 32'(pc_we_o), 0);
    check("lu_ifid_we", 32'(ifid_we_o), 0);
    check("lu_bubble", 32'(idex_bubble_o), 1);
    tick();
    clr_in();
    check("lu_stall_cnt", 32'(stall_cnt_o), 1);

    // Same pattern with rd=x0: no stall.
    ex_memrd_i = 1'b1; ex_rd_i = 5'd0; id_use_rs2_i = 1'b1; id_use_rs1_i = 1'b1;
    #1;
    check("x0_bubble", 32'(idex_bubble_o), 0);
    check("x0_pc_we", 32'(pc_we_o), 1);
    tick();
    clr_in();
    check("x0_stall_cnt", 32'(stall_cnt_o), 1);

    // Rs1-only match also stalls.
    ex_memrd_i = 1'b1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_use_rs1_i = 1'b1;
    #1;
    check("lu_rs1_bubble", 32'(idex_bubble_o), 1);
    tick();
    clr_in();
    check("lu_rs1_cnt", 32'(stall_cnt_o), 2);

    // Taken branch coincident with load-use: branch wins.
    set_lu();
    mem_pcsrc_i = 1'b1;
    #1;
    check("br_flushes", {29'd0, ifid_flush_o, idex_flush_o, exmem_flush_o}, 32'h7);
    check("br_pc_we", 32'(pc_we_o), 1);
    check("br_no_bubble", 32'(idex_bubble_o), 0);
    tick();
    clr_in();
    check("br_flush_cnt", 32'(flush_cnt_o), 1);
    check("br_stall_cnt", 32'(stall_cnt_o), 2);

    // Memory not ready for 3 cycles.
    mem_access_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_hold%0d", i), 32'(hold_o), 1);
      check($sformatf("mw_pc_we%0d", i), 32'(pc_we_o), 0);
      tick();
      check($sformatf("mw_state%0d", i), 32'(state_o), 2);
    end
    dmem_ready_i = 1'b1;
    #1;
    check("mw_rel_hold", 32'(hold_o), 0);
    check("mw_rel_pc_we", 32'(pc_we_o), 1);
    tick();
    clr_in();
    check("mw_back_run", 32'(state_o), 1);
    check("mw_wait_cnt", 32'(wait_cnt_o), 3);
    check("mw_no_err", 32'(err_o), 0);

    // Six wait cycles: err rises after the fourth.
    mem_access_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("to_err%0d", i), 32'(err_o), (i >= 4) ? 1 : 0);
    end
    check("to_wait_cnt", 32'(wait_cnt_o), 9);
    // Release with a pending taken branch: branch acts in the release cycle.
    dmem_ready_i = 1'b1; mem_pcsrc_i = 1'b1;
    #1;
    check("rel_br_flush", 32'(ifid_flush_o), 1);
    tick();
    clr_in();
    check("rel_state", 32'(state_o), 1);
    check("rel_flush_cnt", 32'(flush_cnt_o), 2);
    check("err_sticky", 32'(err_o), 1);

    // Asynchronous reset pulse clears everything.
    start_i = 1'b0;
    #1;
    check("pulse_state", 32'(state_o), 0);
    check("pulse_err", 32'(err_o), 0);
    check("pulse_cnts", {20'd0, stall_cnt_o, flush_cnt_o, wait_cnt_o}, 0);
    check("pulse_flush", 32'(ifid_flush_o), 1);
    #1;
    start_i = 1'b1;
    tick();
    check("pulse_run", 32'(state_o), 1);

    // Saturation of the 4-bit stall counter.
    set_lu();
    for (int i = 0; i < 15; i++) tick();
    check("sat_reach", 32'(stall_cnt_o), 15);
    tick();
    check("sat_hold", 32'(stall_cnt_o), 15);
    clr_in();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
